// File: rtl/buf_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one four-phase BUF sender port among N_SRC Senders.
// The grant is held for the whole REQ/ACK cycle, and completed transfers are counted.
module buf_arbiter #(
  parameter int N_SRC = 4,
  parameter int DW    = 32,
  parameter int CW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    s_req,
  input  logic [N_SRC*DW-1:0] s_di,
  output logic [N_SRC-1:0]    s_ack,
  output logic                b_req,
  output logic [DW-1:0]       b_di,
  input  logic                b_ack,
  output logic [N_SRC-1:0]    grant,
  output logic                busy,
  output logic [CW-1:0]       xfer_count,
  output logic                proto_err
);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(N_SRC - 1);

  typedef enum logic [1:0] {IDLE, REQ, ACKD, RELEASE} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    owner, owner_nxt, last, last_nxt, pick;
  logic             pick_vld;
  logic [N_SRC-1:0] s_ack_nxt, grant_nxt;
  logic             b_req_nxt, busy_nxt, proto_err_nxt;
  logic [DW-1:0]    b_di_nxt;
  logic [CW-1:0]    xfer_count_nxt;

  // Cyclic scan starting just after the previous owner; the first requester wins.
  always_comb begin
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = int'(last) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!pick_vld && s_req[idx]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last       <= LAST_RST;
      s_ack      <= '0;
      grant      <= '0;
      b_req      <= 1'b0;
      b_di       <= '0;
      busy       <= 1'b0;
      xfer_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last       <= last_nxt;
      s_ack      <= s_ack_nxt;
      grant      <= grant_nxt;
      b_req      <= b_req_nxt;
      b_di       <= b_di_nxt;
      busy       <= busy_nxt;
      xfer_count <= xfer_count_nxt;
      proto_err  <= proto_err_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld)      state_nxt = REQ;
      REQ:     if (b_ack)         state_nxt = ACKD;
      ACKD:    if (!s_req[owner]) state_nxt = RELEASE;
      RELEASE: if (!b_ack)        state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    owner_nxt      = owner;
    last_nxt       = last;
    s_ack_nxt      = s_ack;
    grant_nxt      = grant;
    b_req_nxt      = b_req;
    b_di_nxt       = b_di;
    busy_nxt       = busy;
    xfer_count_nxt = xfer_count;
    proto_err_nxt  = proto_err;
    case (state)
      IDLE: begin
        if (b_ack) proto_err_nxt = 1'b1;
        if (pick_vld) begin
          owner_nxt = pick;
          grant_nxt = N_SRC'(1) << pick;
          b_di_nxt  = s_di[pick*DW +: DW];
          b_req_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      REQ: begin
        // A Sender withdrawing early is flagged, but the BUF cycle is never aborted.
        if (!s_req[owner]) proto_err_nxt = 1'b1;
        if (b_ack) s_ack_nxt[owner] = 1'b1;
      end
      ACKD: begin
        if (!b_ack) proto_err_nxt = 1'b1;
        if (!s_req[owner]) b_req_nxt = 1'b0;
      end
      RELEASE: begin
        if (!b_ack) begin
          s_ack_nxt      = '0;
          grant_nxt      = '0;
          busy_nxt       = 1'b0;
          last_nxt       = owner;
          xfer_count_nxt = xfer_count + CW'(1);
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_buf_arbiter.sv
`timescale 1ns/1ps
// Bench for buf_arbiter: vector table, handshake sequences for the corner cases,
// and a randomized Sender/BUF population checked against a transaction-level model.
module tb_buf_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]    s_req;
  logic [N*DW-1:0] s_di;
  logic [N-1:0]    s_ack;
  logic          b_req;
  logic [DW-1:0] b_di;
  logic          b_ack;
  logic [N-1:0]  grant;
  logic          busy;
  logic [CW-1:0] xfer_count;
  logic          proto_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  buf_arbiter #(.N_SRC(N), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .s_req(s_req), .s_di(s_di), .s_ack(s_ack),
    .b_req(b_req), .b_di(b_di), .b_ack(b_ack), .grant(grant), .busy(busy),
    .xfer_count(xfer_count), .proto_err(proto_err)
  );

  typedef struct {
    logic [3:0]  req;
    logic        ack;
    logic [3:0]  e_grant;
    logic        e_breq;
    logic [3:0]  e_sack;
    logic        e_busy;
    logic [3:0]  e_cnt;
    logic        chk_di;
    logic [31:0] e_di;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] onehot(input int g);
    return 4'b0001 << g;
  endfunction

  // Round-robin rule: first requester found scanning last+1, last+2, ... modulo N.
  function automatic int rr_pick(input logic [3:0] req, input int last_owner);
    for (int k = 1; k <= N; k++)
      if (req[(last_owner + k) % N]) return (last_owner + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    rst   = 1'b1;
    s_req = '0;
    b_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Acts as a well-behaved Sender exp_g plus BUF for one complete transfer.
  task automatic serve(input int exp_g, input bit keep, input int exp_cnt);
    int t;
    t = 0;
    while (grant == '0 && t < 40) begin @(negedge clk); t++; end
    check("grant_order", 64'(grant), 64'(onehot(exp_g)));
    b_ack = 1'b1;
    t = 0;
    while (s_ack[exp_g] !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    check("ack_forward", 64'(s_ack), 64'(onehot(exp_g)));
    s_req[exp_g] = 1'b0;
    t = 0;
    while (b_req !== 1'b0 && t < 40) begin @(negedge clk); t++; end
    check("req_withdraw", 64'(b_req), 64'd0);
    b_ack = 1'b0;
    t = 0;
    while (grant != '0 && t < 40) begin @(negedge clk); t++; end
    check("release_grant", 64'(grant), 64'd0);
    check("release_count", 64'(xfer_count), 64'(exp_cnt));
    if (keep) s_req[exp_g] = 1'b1;
  endtask

  int          m_last, m_cnt, m_owner, w;
  logic        prev_busy;
  logic [3:0]  prev_req, prev_grant;
  logic [N*DW-1:0] prev_di;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b1, 32'd0};
    vecs[1] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b1, 4'd0, 1'b1, 32'd5};
    vecs[2] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b1, 4'd0, 1'b1, 32'd5};
    vecs[3] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'd0, 1'b1, 32'd5};
    vecs[4] = '{4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'd0, 1'b1, 32'd5};
    vecs[5] = '{4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'd0, 1'b1, 32'd5};
    vecs[6] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd1, 1'b0, 32'd0};
    vecs[7] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd1, 1'b0, 32'd0};

    rst   = 1'b1;
    s_req = '0;
    b_ack = 1'b0;
    s_di  = {32'h3333_3333, 32'h0000_0005, 32'h1111_1111, 32'h0000_0000};
    @(negedge clk);
    check("reset_sack",  64'(s_ack), 64'd0);
    check("reset_breq",  64'(b_req), 64'd0);
    check("reset_bdi",   64'(b_di), 64'd0);
    check("reset_grant", 64'(grant), 64'd0);
    check("reset_busy",  64'(busy), 64'd0);
    check("reset_count", 64'(xfer_count), 64'd0);
    check("reset_err",   64'(proto_err), 64'd0);
    rst = 1'b0;

    // Single requester: Sender 2 sends 5.
    for (int i = 0; i < 8; i++) begin
      s_req = vecs[i].req;
      b_ack = vecs[i].ack;
      @(negedge clk);
      check($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].e_grant));
      check($sformatf("vec%0d_breq", i),  64'(b_req), 64'(vecs[i].e_breq));
      check($sformatf("vec%0d_sack", i),  64'(s_ack), 64'(vecs[i].e_sack));
      check($sformatf("vec%0d_busy", i),  64'(busy), 64'(vecs[i].e_busy));
      check($sformatf("vec%0d_count", i), 64'(xfer_count), 64'(vecs[i].e_cnt));
      check($sformatf("vec%0d_err", i),   64'(proto_err), 64'd0);
      if (vecs[i].chk_di) check($sformatf("vec%0d_bdi", i), 64'(b_di), 64'(vecs[i].e_di));
    end

    // All four request continuously: order 0,1,2,3,0,1,2,3.
    do_reset();
    s_req = 4'b1111;
    for (int k = 0; k < 8; k++) serve(k % 4, 1'b1, k + 1);
    check("rr8_count", 64'(xfer_count), 64'd8);

    // Senders 0 and 3 contend: strict alternation.
    do_reset();
    s_req = 4'b1001;
    for (int k = 0; k < 4; k++) serve((k % 2 == 0) ? 0 : 3, 1'b1, k + 1);

    // Sender 1 withdraws early while in REQ.
    do_reset();
    s_req = 4'b0010;
    @(negedge clk);
    check("perr_grant", 64'(grant), 64'b0010);
    s_req = 4'b0000;
    @(negedge clk);
    check("perr_flag", 64'(proto_err), 64'd1);
    check("perr_breq_hold", 64'(b_req), 64'd1);
    @(negedge clk);
    check("perr_breq_hold2", 64'(b_req), 64'd1);
    b_ack = 1'b1;
    @(negedge clk);
    check("perr_sack", 64'(s_ack), 64'b0010);
    @(negedge clk);
    check("perr_breq_low", 64'(b_req), 64'd0);
    b_ack = 1'b0;
    @(negedge clk);
    check("perr_release", 64'(grant), 64'd0);
    check("perr_count", 64'(xfer_count), 64'd1);
    repeat (3) @(negedge clk);
    check("perr_sticky", 64'(proto_err), 64'd1);
    do_reset();
    check("perr_cleared", 64'(proto_err), 64'd0);

    // Reset asserted while in ACKD.
    s_req = 4'b0100;
    @(negedge clk);
    check("mid_grant", 64'(grant), 64'b0100);
    b_ack = 1'b1;
    @(negedge clk);
    check("mid_ackd", 64'(s_ack), 64'b0100);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sack",  64'(s_ack), 64'd0);
    check("mid_rst_grant", 64'(grant), 64'd0);
    check("mid_rst_breq",  64'(b_req), 64'd0);
    check("mid_rst_bdi",   64'(b_di), 64'd0);
    check("mid_rst_busy",  64'(busy), 64'd0);
    s_req = 4'b1010;
    b_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_regrant", 64'(grant), 64'b0010);
    check("mid_uncounted", 64'(xfer_count), 64'd0);
    serve(1, 1'b0, 1);
    serve(3, 1'b0, 2);

    // Counter wrap at 2^CW.
    do_reset();
    s_req = 4'b0001;
    for (int k = 0; k < 17; k++) serve(0, 1'b1, (k + 1) % 16);
    s_req = 4'b0000;

    // Randomized population of well-behaved Senders and a BUF with random latency.
    do_reset();
    m_last     = N - 1;
    m_cnt      = 0;
    m_owner    = 0;
    prev_busy  = 1'b0;
    prev_req   = '0;
    prev_grant = '0;
    prev_di    = s_di;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      if (!prev_busy && prev_req != '0) begin
        w = rr_pick(prev_req, m_last);
        check("rand_grant", 64'(grant), 64'(onehot(w)));
        check("rand_data", 64'(b_di), 64'(prev_di[w*DW +: DW]));
        m_owner = w;
      end
      if (prev_grant != '0 && grant == '0) begin
        m_cnt  = (m_cnt + 1) % 16;
        m_last = m_owner;
        check("rand_count", 64'(xfer_count), 64'(m_cnt));
      end
      if ((s_ack & ~grant) != '0) check("rand_stray_ack", 64'(s_ack & ~grant), 64'd0);
      for (int i = 0; i < N; i++) begin
        if (s_req[i] && s_ack[i]) begin
          if ($urandom_range(0, 1) == 0) s_req[i] = 1'b0;
        end else if (!s_req[i] && !s_ack[i] && cyc < 500 && $urandom_range(0, 3) == 0) begin
          s_di[i*DW +: DW] = $urandom;
          s_req[i] = 1'b1;
        end
      end
      if (b_req && !b_ack && $urandom_range(0, 1) == 0) b_ack = 1'b1;
      else if (!b_req && b_ack && $urandom_range(0, 1) == 0) b_ack = 1'b0;
      prev_busy  = busy;
      prev_req   = s_req;
      prev_di    = s_di;
      prev_grant = grant;
    end
    check("rand_idle", 64'(busy), 64'd0);
    check("rand_final_count", 64'(xfer_count), 64'(m_cnt));
    check("rand_no_err", 64'(proto_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
